// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types for the UART receiver and its receive FIFO
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_PUSH
  } rx_state_e;

  localparam int MAX_DATA_BITS = 9;

  // Widest possible received entry; narrower frames zero-extend the payload.
  typedef struct packed {
    logic                     parity_err;
    logic                     frame_err;
    logic [MAX_DATA_BITS-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - generic synchronous FIFO; a pop on a full FIFO lets a same-cycle push in
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNTW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage is reset so the head reads as zero while empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rcvr_fifo.sv
// rtl/uart_rcvr_fifo.sv - UART receiver with majority-vote sampling, error tagging, receive FIFO and RTS
module uart_rcvr_fifo
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 54,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 16,
  parameter int      RTS_HEADROOM = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] m_data_o,
  output logic                 m_frame_err_o,
  output logic                 m_parity_err_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 rts_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] HALF_P1  = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DAT = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STP = IW'(STOP_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic                 s0_q, s1_q, vote;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d;
  logic                 resolve, bit_end, push;
  logic                 fifo_full, fifo_empty;
  logic [CNTW-1:0]      fifo_count;
  logic                 rts_q, overrun_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      if (bit_cnt_q == HALF_M1) s0_q <= rx_s_q;
      if (bit_cnt_q == HALF)    s1_q <= rx_s_q;
    end
  end

  // Third sample is the live one, so each bit is decided on cycle HALF+1.
  assign vote    = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
  assign resolve = (bit_cnt_q == HALF_P1);
  assign bit_end = (bit_cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_end ? '0 : bit_cnt_q + CW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s_q && rx_prev_q) begin
          state_d = ST_START;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (resolve && vote) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (resolve) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (idx_q == LAST_DAT) begin
            idx_d   = '0;
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (resolve) perr_d = ((^shift_q) ^ vote) != (PARITY == PAR_ODD);
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leave on the last stop's decision so a start edge right after it is not missed.
        if (resolve) begin
          if (!vote) ferr_d = 1'b1;
          if (idx_q == LAST_STP) state_d = ST_PUSH;
        end
        if (bit_end) idx_d = idx_q + IW'(1);
      end
      ST_PUSH: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      rts_q     <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      rts_q     <= (CNTW'(FIFO_DEPTH) - fifo_count) > CNTW'(RTS_HEADROOM);
      overrun_q <= push & fifo_full & ~m_ready_i;
    end
  end

  uart_rx_fifo #(
    .WIDTH(DATA_BITS + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .pop_i   (m_ready_i),
    .wdata_i ({perr_q, ferr_q, shift_q}),
    .rdata_o ({m_parity_err_o, m_frame_err_o, m_data_o}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_valid_o = ~fifo_empty;
  assign rts_o     = rts_q;
  assign overrun_o = overrun_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rcvr_fifo.sv
// tb/tb_uart_rcvr_fifo.sv - self-checking bench for uart_rcvr_fifo against a frame-level model
module tb_uart_rcvr_fifo;
  import uart_pkg::*;

  localparam int CPB_A = 54, DEPTH_A = 16, HEAD_A = 4;
  localparam int CPB_B = 21, DEPTH_B = 4,  HEAD_B = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b0, rdy_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic ferr_a, perr_a, valid_a, rts_a, ovr_a, busy_a;
  logic ferr_b, perr_b, valid_b, rts_b, ovr_b, busy_b;

  int checks = 0, errors = 0;
  uart_rx_entry_t exp_a[$], exp_b[$];
  int exp_ovr_a = 0;

  int   busy_falls_a = 0, ovr_cnt_a = 0;
  logic busy_d_a = 1'b0, last_busy_valid_a = 1'b0, fall_valid_a = 1'b0;

  initial forever #5 clk = ~clk;

  uart_rcvr_fifo #(
    .CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1),
    .FIFO_DEPTH(DEPTH_A), .RTS_HEADROOM(HEAD_A)
  ) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .uart_rx_i(rx_a), .m_data_o(data_a),
    .m_frame_err_o(ferr_a), .m_parity_err_o(perr_a), .m_valid_o(valid_a),
    .m_ready_i(rdy_a), .rts_o(rts_a), .overrun_o(ovr_a), .busy_o(busy_a)
  );

  uart_rcvr_fifo #(
    .CLKS_PER_BIT(CPB_B), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(2),
    .FIFO_DEPTH(DEPTH_B), .RTS_HEADROOM(HEAD_B)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .uart_rx_i(rx_b), .m_data_o(data_b),
    .m_frame_err_o(ferr_b), .m_parity_err_o(perr_b), .m_valid_o(valid_b),
    .m_ready_i(rdy_b), .rts_o(rts_b), .overrun_o(ovr_b), .busy_o(busy_b)
  );

  always @(negedge clk) begin
    if (busy_d_a && !busy_a) begin
      fall_valid_a = valid_a;
      busy_falls_a++;
    end else if (busy_a) begin
      last_busy_valid_a = valid_a;
    end
    busy_d_a = busy_a;
    if (ovr_a) ovr_cnt_a++;
  end

  task automatic drive_line(input bit sel_b, input logic v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (sel_b) rx_b = v; else rx_a = v;
      @(posedge clk);
    end
  endtask

  // Drives one frame and records what the receiver must deliver for it.
  task automatic send_frame(input bit sel_b, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops, input int spike_bit, input int gap);
    int cpb, nst, n;
    logic [15:0] v;
    uart_rx_entry_t e;
    cpb = sel_b ? CPB_B : CPB_A;
    nst = sel_b ? 2 : 1;
    e.data       = {1'b0, d};
    e.frame_err  = (stops[0] == 1'b0) || (sel_b && stops[1] == 1'b0);
    e.parity_err = sel_b ? ((($countones(d) + int'(pbit)) % 2) != 0) : 1'b0;
    if (sel_b) begin
      if (exp_b.size() < DEPTH_B) exp_b.push_back(e);
    end else begin
      if (exp_a.size() < DEPTH_A) exp_a.push_back(e);
      else exp_ovr_a++;
    end
    v = '0;
    n = 1;
    for (int i = 0; i < 8; i++) begin v[n] = d[i]; n++; end
    if (sel_b) begin v[n] = pbit; n++; end
    for (int s = 0; s < nst; s++) begin v[n] = stops[s]; n++; end
    for (int k = 0; k < n; k++) begin
      if (k == spike_bit) begin
        drive_line(sel_b, v[k], cpb / 2);
        drive_line(sel_b, ~v[k], 1);
        drive_line(sel_b, v[k], cpb - cpb / 2 - 1);
      end else begin
        drive_line(sel_b, v[k], cpb);
      end
    end
    drive_line(sel_b, 1'b1, gap);
  endtask

  task automatic pop_entry(input bit sel_b, output uart_rx_entry_t got, output bit timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    @(negedge clk);
    while (!(sel_b ? valid_b : valid_a)) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin timed_out = 1'b1; break; end
    end
    got.data       = {1'b0, sel_b ? data_b : data_a};
    got.frame_err  = sel_b ? ferr_b : ferr_a;
    got.parity_err = sel_b ? perr_b : perr_a;
    if (!timed_out) begin
      if (sel_b) rdy_b = 1'b1; else rdy_a = 1'b1;
      @(negedge clk);
      rdy_a = 1'b0;
      rdy_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    repeat (3) @(negedge clk);
    obs = {valid_a, data_a, ferr_a, perr_a, rts_a, ovr_a, busy_a};
    checks++;
    if (obs !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_a: got %b expected 0_00000000_0_0_1_0_0", obs);
    end
    obs = {valid_b, data_b, ferr_b, perr_b, rts_b, ovr_b, busy_b};
    checks++;
    if (obs !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_b: got %b expected 0_00000000_0_0_1_0_0", obs);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({valid_a, busy_a, rts_a} !== 3'b001) begin
      errors++; $display("FAIL post_reset_idle: valid/busy/rts %b expected 001", {valid_a, busy_a, rts_a});
    end
  endtask

  task automatic test_basic();
    uart_rx_entry_t got, exp;
    bit to;
    int falls0;
    falls0 = busy_falls_a;
    send_frame(1'b0, 8'h55, 1'b0, 2'b11, -1, 5);
    checks++;
    if (busy_falls_a - falls0 != 1 || last_busy_valid_a !== 1'b0 || fall_valid_a !== 1'b1) begin
      errors++; $display("FAIL latency: falls %0d valid_in_push %b valid_after %b expected 1 0 1",
                         busy_falls_a - falls0, last_busy_valid_a, fall_valid_a);
    end
    pop_entry(1'b0, got, to);
    exp = exp_a.pop_front();
    checks++;
    if (to || got !== exp) begin
      errors++; $display("FAIL basic_55: got %h timeout %0d expected %h", got, to, exp);
    end
    checks++;
    if (got.data !== 9'h055 || got.frame_err !== 1'b0) begin
      errors++; $display("FAIL basic_55_const: got data %h ferr %b expected 055 0", got.data, got.frame_err);
    end
  endtask

  task automatic test_random_a();
    uart_rx_entry_t got, exp;
    bit to;
    logic [7:0] d;
    logic st;
    int sp;
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1;
      send_frame(1'b0, d, 1'b0, {1'b1, st}, sp, st ? int'($urandom_range(0, 30)) : 10);
      pop_entry(1'b0, got, to);
      exp = exp_a.pop_front();
      checks++;
      if (to || got !== exp) begin
        errors++; $display("FAIL random_a[%0d]: got %h timeout %0d expected %h", i, got, to, exp);
      end
    end
  endtask

  task automatic test_frame_err();
    uart_rx_entry_t got, exp;
    bit to;
    send_frame(1'b0, 8'h0F, 1'b0, 2'b10, -1, 10);
    pop_entry(1'b0, got, to);
    exp = exp_a.pop_front();
    checks++;
    if (to || got !== exp || got.frame_err !== 1'b1) begin
      errors++; $display("FAIL frame_err_0f: got %h timeout %0d expected %h", got, to, exp);
    end
    send_frame(1'b0, 8'h3C, 1'b0, 2'b11, -1, 3);
    pop_entry(1'b0, got, to);
    exp = exp_a.pop_front();
    checks++;
    if (to || got !== exp) begin
      errors++; $display("FAIL frame_after_err: got %h timeout %0d expected %h", got, to, exp);
    end
    // Line held low for many bit times: one all-zero frame with a bad stop, then no re-arm.
    exp.data = 9'h000; exp.frame_err = 1'b1; exp.parity_err = 1'b0;
    drive_line(1'b0, 1'b0, 15 * CPB_A);
    drive_line(1'b0, 1'b1, 100);
    pop_entry(1'b0, got, to);
    checks++;
    if (to || got !== exp) begin
      errors++; $display("FAIL break_frame: got %h timeout %0d expected %h", got, to, exp);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL break_no_rearm: valid %b busy %b expected 0 0", valid_a, busy_a);
    end
  endtask

  task automatic test_glitch();
    int falls0, busy_seen;
    falls0 = busy_falls_a;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      rx_a = 1'b0;
      @(negedge clk);
      if (busy_a) busy_seen++;
    end
    rx_a = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy_a) busy_seen++;
    end
    checks++;
    if (busy_seen == 0 || busy_falls_a - falls0 != 1) begin
      errors++; $display("FAIL glitch_armed: busy cycles %0d falls %0d expected >0 and 1", busy_seen, busy_falls_a - falls0);
    end
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL glitch_no_push: valid %b busy %b expected 0 0", valid_a, busy_a);
    end
  endtask

  task automatic test_spike();
    uart_rx_entry_t got, exp;
    bit to;
    for (int b = 0; b < 10; b++) begin
      send_frame(1'b0, 8'hFF, 1'b0, 2'b11, b, 4);
      pop_entry(1'b0, got, to);
      exp = exp_a.pop_front();
      checks++;
      if (to || got !== exp || got.data !== 9'h0FF) begin
        errors++; $display("FAIL spike_bit%0d: got %h timeout %0d expected %h", b, got, to, exp);
      end
    end
  endtask

  task automatic test_parity();
    uart_rx_entry_t got, exp;
    bit to;
    logic [1:0] st;
    for (int w = 0; w < 2; w++) begin
      send_frame(1'b1, 8'hA3, (w == 0) ? 1'b1 : 1'b0, 2'b11, -1, 4);
      pop_entry(1'b1, got, to);
      exp = exp_b.pop_front();
      checks++;
      if (to || got !== exp || got.parity_err !== (w == 0)) begin
        errors++; $display("FAIL parity_a3_%0d: got %h timeout %0d expected %h", w, got, to, exp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      st[0] = ($urandom_range(0, 4) != 0);
      st[1] = ($urandom_range(0, 4) != 0);
      send_frame(1'b1, 8'($urandom), 1'($urandom), st, -1, (st == 2'b11) ? int'($urandom_range(0, 10)) : 5);
      pop_entry(1'b1, got, to);
      exp = exp_b.pop_front();
      checks++;
      if (to || got !== exp) begin
        errors++; $display("FAIL parity_rand[%0d]: got %h timeout %0d expected %h", i, got, to, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    uart_rx_entry_t got, exp;
    bit to;
    int occ, ovr0;
    logic exp_rts;
    ovr0 = exp_ovr_a;
    for (int k = 1; k <= 17; k++) begin
      send_frame(1'b0, 8'($urandom), 1'b0, 2'b11, -1, 0);
      #1;
      occ = (k > DEPTH_A) ? DEPTH_A : k;
      exp_rts = (DEPTH_A - occ) > HEAD_A;
      checks++;
      if (rts_a !== exp_rts) begin
        errors++; $display("FAIL flood_rts[%0d]: got %b expected %b", k, rts_a, exp_rts);
      end
    end
    checks++;
    if (ovr_cnt_a !== exp_ovr_a || exp_ovr_a - ovr0 != 1) begin
      errors++; $display("FAIL flood_overrun: pulses %0d expected %0d", ovr_cnt_a, exp_ovr_a);
    end
    for (int i = 0; i < DEPTH_A; i++) begin
      pop_entry(1'b0, got, to);
      exp = exp_a.pop_front();
      checks++;
      if (to || got !== exp) begin
        errors++; $display("FAIL drain[%0d]: got %h timeout %0d expected %h", i, got, to, exp);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rts_a !== 1'b1 || valid_a !== 1'b0) begin
      errors++; $display("FAIL drained: rts %b valid %b expected 1 0", rts_a, valid_a);
    end
  endtask

  task automatic test_reset_mid_frame();
    uart_rx_entry_t got, exp;
    bit to;
    send_frame(1'b0, 8'h81, 1'b0, 2'b11, -1, 5);
    drive_line(1'b0, 1'b0, CPB_A);
    drive_line(1'b0, 1'b1, CPB_A);
    drive_line(1'b0, 1'b0, 20);
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++; $display("FAIL pre_reset: valid %b busy %b expected 1 1", valid_a, busy_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_a, busy_a, rts_a, data_a} !== {3'b001, 8'h00}) begin
      errors++; $display("FAIL async_reset: valid/busy/rts/data %b expected 001_00000000", {valid_a, busy_a, rts_a, data_a});
    end
    rx_a = 1'b1;
    exp_a.delete();
    exp_b.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if ({valid_a, busy_a, rts_a} !== 3'b001) begin
      errors++; $display("FAIL after_reset_empty: valid/busy/rts %b expected 001", {valid_a, busy_a, rts_a});
    end
    send_frame(1'b0, 8'hC3, 1'b0, 2'b11, -1, 5);
    pop_entry(1'b0, got, to);
    exp = exp_a.pop_front();
    checks++;
    if (to || got !== exp) begin
      errors++; $display("FAIL after_reset_frame: got %h timeout %0d expected %h", got, to, exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_a();
    test_frame_err();
    test_glitch();
    test_spike();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
